// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// Holds the FSM state encoding, channel index constants, the reset value of the
// round-robin pointer and the winner-search result type.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    // Pointer starts at the last channel so channel A has first priority.
    localparam logic [1:0] LAST_RST = 2'd3;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } winner_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4_w.sv
// Parameterised WIDTH-bit 4:1 combinational multiplexer.
// Ports:
//   a, b, c, d : channel data inputs
//   sel        : channel index (0 -> a ... 3 -> d)
//   out        : selected channel data
module mux4_w
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = a;
        case (sel)
            CH_A:    out = a;
            CH_B:    out = b;
            CH_C:    out = c;
            CH_D:    out = d;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing a 4:1 WIDTH-bit selector between four requesters.
// A grant lasts until the owner drops its request or holds it for MAX_HOLD
// cycles; the next owner is then chosen by rotating priority in the same edge.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   req      : request bits, req[0] -> a ... req[3] -> d
//   a..d     : channel data
//   gnt      : one-hot grant, zero when idle
//   sel      : index of the current / last owner
//   data_out : channel data selected by the registered sel
//   valid    : high while a grant is active (== |gnt)
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 3   // MAX_HOLD must fit: MAX_HOLD <= 2**CNT_W-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    winner_t win_idle;
    winner_t win_rel;
    logic    release_now;

    // Search req starting one past ptr, wrapping mod 4; first set bit wins.
    function automatic winner_t find_winner(input logic [3:0] r, input logic [1:0] ptr);
        winner_t    w;
        logic [1:0] k;
        w.found = 1'b0;
        w.idx   = ptr;
        for (int i = 1; i <= 4; i++) begin
            k = ptr + 2'(i);
            if (!w.found && r[k]) begin
                w.found = 1'b1;
                w.idx   = k;
            end
        end
        return w;
    endfunction

    // On release the pointer moves to the owner, so the search starts after it.
    assign win_idle    = find_winner(req, last_q);
    assign win_rel     = find_winner(req, sel_q);
    assign release_now = !req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (win_idle.found) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot4(win_idle.idx);
                    sel_d   = win_idle.idx;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    last_d = sel_q;
                    if (win_rel.found) begin
                        // Handover (or re-grant of the sole requester) without a gap.
                        gnt_d = onehot4(win_rel.idx);
                        sel_d = win_rel.idx;
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= CH_A;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = |gnt_q;

    mux4_w #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .sel(sel_q),
        .out(data_out)
    );

endmodule
